// File: rtl/riscv_pkg.sv
// Shared definitions for the hazard/sequencing controller of the 5-stage core.
//   hz_state_e : controller FSM states (RUN, MDU_WAIT)
//   REG_X0     : index of the hard-wired zero register
//   CNT_W_DEF  : default performance counter width
package riscv_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0    = 5'd0;
  localparam int         CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear, wins over inc
//   inc        : increment request, ignored once count is all ones
//   count      : current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller. Combines load-use hazards,
// EX redirects, instruction-memory wait and the MDU handshake into PC
// enable and IF/ID / ID/EX stall-flush controls; counts stall and
// redirect cycles.
//   Inputs : id_rs1/rs2, id_uses_rs1/rs2, id_is_mdu, ex_mem_read, ex_rd,
//            ex_redirect, imem_ready, mdu_done, clr_cnt
//   Outputs: pc_write, if_id_stall, if_id_flush, id_ex_flush,
//            mdu_start, mdu_abort, stall_cnt, flush_cnt,
//            dbg_state (current FSM state, for observation only)
// Handshake: mdu_start/mdu_abort are single-cycle pulses; mdu_done is a
// single-cycle pulse from the MDU and is only honoured in MDU_WAIT.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_is_mdu,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             mdu_done,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mdu_start,
  output logic             mdu_abort,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output hz_state_e        dbg_state
);

  hz_state_e r_state;
  hz_state_e w_state_nxt;
  logic      w_lu;

  // x0 never carries a real dependency, so a load to x0 cannot stall.
  assign w_lu = ex_mem_read && (ex_rd != REG_X0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    pc_write    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mdu_start   = 1'b0;
    mdu_abort   = 1'b0;
    unique case (r_state)
      RUN: begin
        if (ex_redirect) begin
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (w_lu) begin
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end else if (id_is_mdu) begin
          mdu_start   = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          w_state_nxt = MDU_WAIT;
        end else if (!imem_ready) begin
          if_id_flush = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
      end
      MDU_WAIT: begin
        // A redirect wins over a coincident mdu_done: the result is dropped.
        if (ex_redirect) begin
          mdu_abort   = 1'b1;
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          w_state_nxt = RUN;
        end else if (mdu_done) begin
          // The held MDU op advances into EX; fetch proceeds only if ready.
          pc_write    = imem_ready;
          if_id_flush = !imem_ready;
          w_state_nxt = RUN;
        end else begin
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      default: w_state_nxt = RUN;
    endcase
    // While in reset the pipeline is held empty regardless of inputs.
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      mdu_start   = 1'b0;
      mdu_abort   = 1'b0;
    end
  end

  assign dbg_state = r_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (if_id_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_cnt),
    .inc   (ex_redirect),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import riscv_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2, id_is_mdu;
  logic             ex_mem_read, ex_redirect, imem_ready, mdu_done, clr_cnt;
  logic             pc_write, if_id_stall, if_id_flush, id_ex_flush;
  logic             mdu_start, mdu_abort;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  hz_state_e        dbg_state;

  int n_checks;
  int n_pass;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_is_mdu   (id_is_mdu),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .imem_ready  (imem_ready),
    .mdu_done    (mdu_done),
    .clr_cnt     (clr_cnt),
    .pc_write    (pc_write),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .mdu_start   (mdu_start),
    .mdu_abort   (mdu_abort),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // driver tasks
  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_is_mdu = 1'b0;
    ex_mem_read = 1'b0; ex_redirect = 1'b0; imem_ready = 1'b1;
    mdu_done = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
  endtask

  // advance one clock; inputs change 2ns after the edge, checks at +3ns
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // ctrl word {pc_write, stall, if_flush, idex_flush, start, abort}
  function automatic logic [5:0] ctrl();
    return {pc_write, if_id_stall, if_id_flush, id_ex_flush, mdu_start, mdu_abort};
  endfunction

  int cnt_a;
  int cnt_b;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    settle();
    chk("reset_ctrl", 32'(ctrl()), 32'(6'b001100));
    chk("reset_state", 32'(dbg_state), 32'(RUN));
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_flush_cnt", 32'(flush_cnt), 0);
    rst_n = 1'b1;
    tick();

    // idle run
    settle();
    chk("idle_ctrl", 32'(ctrl()), 32'(6'b100000));

    // load-use: one stall cycle, then bubble clears it
    set_lu(5'd5);
    settle();
    chk("lu_ctrl", 32'(ctrl()), 32'(6'b010100));
    tick();
    idle_inputs();
    settle();
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_after_ctrl", 32'(ctrl()), 32'(6'b100000));
    // load to x0 with matching source index x0 -> no hazard
    set_lu(5'd0);
    id_rs1 = 5'd0;
    settle();
    chk("lu_x0_ctrl", 32'(ctrl()), 32'(6'b100000));
    tick();
    idle_inputs();

    // redirect beats load-use
    set_lu(5'd5);
    ex_redirect = 1'b1;
    id_is_mdu = 1'b1;
    settle();
    chk("redir_lu_ctrl", 32'(ctrl()), 32'(6'b101100));
    tick();
    idle_inputs();
    settle();
    chk("redir_flush_cnt", 32'(flush_cnt), 1);
    chk("redir_stall_cnt", 32'(stall_cnt), 1);
    chk("redir_state", 32'(dbg_state), 32'(RUN));

    // MDU: start cycle, 5 wait cycles, then mdu_done
    id_is_mdu = 1'b1;
    settle();
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      if (if_id_stall) cnt_a++;
      if (mdu_start) cnt_b++;
      tick();
      settle();
    end
    chk("mdu_stall_cycles", 32'(cnt_a), 6);
    chk("mdu_start_pulses", 32'(cnt_b), 1);
    chk("mdu_wait_state", 32'(dbg_state), 32'(MDU_WAIT));
    mdu_done = 1'b1;
    settle();
    chk("mdu_done_ctrl", 32'(ctrl()), 32'(6'b100000));
    tick();
    idle_inputs();
    settle();
    chk("mdu_after_state", 32'(dbg_state), 32'(RUN));
    chk("mdu_after_ctrl", 32'(ctrl()), 32'(6'b100000));
    chk("mdu_stall_cnt", 32'(stall_cnt), 7);

    // MDU abort on the 3rd wait cycle
    id_is_mdu = 1'b1;
    tick();
    tick();
    tick();
    ex_redirect = 1'b1;
    settle();
    chk("abort_ctrl", 32'(ctrl()), 32'(6'b101101));
    tick();
    idle_inputs();
    settle();
    chk("abort_state", 32'(dbg_state), 32'(RUN));
    mdu_done = 1'b1;
    settle();
    chk("late_done_ctrl", 32'(ctrl()), 32'(6'b100000));
    tick();
    idle_inputs();
    settle();
    chk("late_done_state", 32'(dbg_state), 32'(RUN));
    chk("abort_flush_cnt", 32'(flush_cnt), 2);
    chk("abort_stall_cnt", 32'(stall_cnt), 10);

    // instruction memory wait for 3 cycles
    imem_ready = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (ctrl() == 6'b001000) cnt_a++;
      tick();
    end
    idle_inputs();
    settle();
    chk("imem_wait_cycles", 32'(cnt_a), 3);
    chk("imem_stall_cnt", 32'(stall_cnt), 10);

    // saturation: 20 load-use cycles
    set_lu(5'd5);
    for (int i = 0; i < 20; i++) tick();
    idle_inputs();
    settle();
    chk("sat_stall_cnt", 32'(stall_cnt), 15);
    clr_cnt = 1'b1;
    tick();
    idle_inputs();
    settle();
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
    chk("clr_flush_cnt", 32'(flush_cnt), 0);

    // async reset in the middle of MDU_WAIT
    id_is_mdu = 1'b1;
    tick();
    tick();
    settle();
    chk("pre_rst_state", 32'(dbg_state), 32'(MDU_WAIT));
    chk("pre_rst_stall_cnt", 32'(stall_cnt), 2);
    rst_n = 1'b0;
    settle();
    chk("async_rst_state", 32'(dbg_state), 32'(RUN));
    chk("async_rst_stall_cnt", 32'(stall_cnt), 0);
    chk("async_rst_ctrl", 32'(ctrl()), 32'(6'b001100));
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();
    settle();
    chk("post_rst_ctrl", 32'(ctrl()), 32'(6'b100000));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
